// File: rtl/morse2ascii_if.sv
// rtl/morse2ascii_if.sv - decoded character valid/ready handshake bundle
interface morse2ascii_if;
  logic [7:0] ascii_out;
  logic       ascii_valid;
  logic       ascii_ready;

  modport master (output ascii_out, output ascii_valid, input ascii_ready);
  modport slave  (input ascii_out, input ascii_valid, output ascii_ready);
endinterface

// File: rtl/morse2ascii.sv
// rtl/morse2ascii.sv - Morse on/off keying decoder producing ASCII characters
module morse2ascii #(
  parameter int PRESCALER = 5_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 morse_in,
  morse2ascii_if.master        out_if,
  output logic                 overflow
);

  localparam int CW = $clog2(8 * PRESCALER + 1);
  localparam logic [CW-1:0] C_LETTER = CW'(2 * PRESCALER);
  localparam logic [CW-1:0] C_WORD   = CW'(5 * PRESCALER);
  localparam logic [CW-1:0] C_SAT    = CW'(8 * PRESCALER);

  typedef enum logic [1:0] {S_IDLE, S_MARK, S_GAP, S_WORD} state_t;

  state_t        r_state;
  logic          r_m_q;
  logic          r_m_prev;
  logic [CW-1:0] r_run_cnt;
  logic [5:0]    r_pattern;
  logic [2:0]    r_elem_cnt;
  logic [7:0]    r_ascii_out;
  logic          r_ascii_valid;
  logic          r_overflow;

  logic          w_edge;
  logic          w_is_dash;
  logic          w_emit;
  logic [7:0]    w_char;

  // Elements are shifted in at the LSB, so the first element of a letter ends
  // up as the most significant of the elem_cnt valid bits.
  function automatic logic [7:0] f_decode(input logic [2:0] cnt, input logic [5:0] pat);
    logic [7:0] ch;
    case ({cnt, pat})
      9'b001_000000: ch = 8'h45; // E .
      9'b001_000001: ch = 8'h54; // T -
      9'b010_000000: ch = 8'h49; // I ..
      9'b010_000001: ch = 8'h41; // A .-
      9'b010_000010: ch = 8'h4E; // N -.
      9'b010_000011: ch = 8'h4D; // M --
      9'b011_000000: ch = 8'h53; // S ...
      9'b011_000001: ch = 8'h55; // U ..-
      9'b011_000010: ch = 8'h52; // R .-.
      9'b011_000011: ch = 8'h57; // W .--
      9'b011_000100: ch = 8'h44; // D -..
      9'b011_000101: ch = 8'h4B; // K -.-
      9'b011_000110: ch = 8'h47; // G --.
      9'b011_000111: ch = 8'h4F; // O ---
      9'b100_000000: ch = 8'h48; // H ....
      9'b100_000001: ch = 8'h56; // V ...-
      9'b100_000010: ch = 8'h46; // F ..-.
      9'b100_000100: ch = 8'h4C; // L .-..
      9'b100_000110: ch = 8'h50; // P .--.
      9'b100_000111: ch = 8'h4A; // J .---
      9'b100_001000: ch = 8'h42; // B -...
      9'b100_001001: ch = 8'h58; // X -..-
      9'b100_001010: ch = 8'h43; // C -.-.
      9'b100_001011: ch = 8'h59; // Y -.--
      9'b100_001100: ch = 8'h5A; // Z --..
      9'b100_001101: ch = 8'h51; // Q --.-
      9'b101_011111: ch = 8'h30; // 0 -----
      9'b101_001111: ch = 8'h31; // 1 .----
      9'b101_000111: ch = 8'h32; // 2 ..---
      9'b101_000011: ch = 8'h33; // 3 ...--
      9'b101_000001: ch = 8'h34; // 4 ....-
      9'b101_000000: ch = 8'h35; // 5 .....
      9'b101_010000: ch = 8'h36; // 6 -....
      9'b101_011000: ch = 8'h37; // 7 --...
      9'b101_011100: ch = 8'h38; // 8 ---..
      9'b101_011110: ch = 8'h39; // 9 ----.
      default:       ch = 8'h3F; // unknown pattern or too many elements
    endcase
    return ch;
  endfunction

  // During the first cycle of a new level run_cnt still holds the length of
  // the level that just ended, which is what mark classification needs.
  assign w_edge    = (r_m_q != r_m_prev);
  assign w_is_dash = (r_run_cnt >= C_LETTER);

  // Register the keying input and count the length of the current level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_q     <= 1'b0;
      r_m_prev  <= 1'b0;
      r_run_cnt <= '0;
    end else begin
      r_m_q    <= morse_in;
      r_m_prev <= r_m_q;
      if (w_edge) begin
        r_run_cnt <= CW'(1);
      end else if (r_run_cnt != C_SAT) begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
    end
  end

  // Detect letter-end and word-gap thresholds and pick the character to present
  always_comb begin
    w_emit = 1'b0;
    w_char = 8'h00;
    case (r_state)
      S_GAP: begin
        if (r_run_cnt == C_LETTER) begin
          w_emit = 1'b1;
          w_char = f_decode(r_elem_cnt, r_pattern);
        end
      end
      S_WORD: begin
        if (r_run_cnt == C_WORD) begin
          w_emit = 1'b1;
          w_char = 8'h20;
        end
      end
      default: ;
    endcase
  end

  // Decoder FSM together with the single-entry output slot and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pattern     <= '0;
      r_elem_cnt    <= '0;
      r_ascii_out   <= 8'h00;
      r_ascii_valid <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_emit) begin
        if (r_ascii_valid && !out_if.ascii_ready) begin
          r_overflow <= 1'b1;
        end else begin
          r_ascii_out   <= w_char;
          r_ascii_valid <= 1'b1;
        end
      end else if (r_ascii_valid && out_if.ascii_ready) begin
        r_ascii_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (r_m_q) r_state <= S_MARK;
        end
        S_MARK: begin
          if (w_edge && !r_m_q) begin
            r_pattern <= {r_pattern[4:0], w_is_dash};
            if (r_elem_cnt != 3'd7) r_elem_cnt <= r_elem_cnt + 3'd1;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          // A gap of exactly the letter threshold can coincide with the next
          // rising edge; the letter is still emitted and the new mark is kept.
          if (w_emit) begin
            r_pattern  <= '0;
            r_elem_cnt <= '0;
            r_state    <= w_edge ? S_MARK : S_WORD;
          end else if (w_edge) begin
            r_state <= S_MARK;
          end
        end
        S_WORD: begin
          if (w_edge) begin
            r_state <= S_MARK;
          end else if (w_emit) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_if.ascii_out   = r_ascii_out;
  assign out_if.ascii_valid = r_ascii_valid;
  assign overflow           = r_overflow;

endmodule

// File: tb/tb_morse2ascii.sv
// tb/tb_morse2ascii.sv - scoreboard bench for the Morse decoder
module tb_morse2ascii;
  localparam int P = 100;

  logic clk = 1'b0;
  logic rst;
  logic morse_in;
  logic overflow;

  morse2ascii_if vif();

  morse2ascii #(.PRESCALER(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .morse_in (morse_in),
    .out_if   (vif),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  bit rand_ready = 0;

  string tbl[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                     ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                     "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                     "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                     "--...", "---..", "----."};

  function automatic logic [7:0] sym(int i);
    return (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
  endfunction

  function automatic logic [7:0] lookup(string code);
    for (int i = 0; i < 36; i++) if (tbl[i] == code) return sym(i);
    return 8'h3F;
  endfunction

  function automatic string code_of(logic [7:0] c);
    for (int i = 0; i < 36; i++) if (sym(i) == c) return tbl[i];
    return "";
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(logic v, int n);
    morse_in = v;
    repeat (n) tick();
  endtask

  // Expected output follows from the intended element string and the gap after it
  task automatic send_letter(string code, int gap, bit rnd);
    int mlen;
    exp_q.push_back(lookup(code));
    if (gap >= 5 * P) exp_q.push_back(8'h20);
    for (int i = 0; i < code.len(); i++) begin
      if (code[i] == 8'h2D)
        mlen = rnd ? (($urandom_range(0, 7) == 0) ? 850 : int'($urandom_range(2 * P, 420))) : 3 * P;
      else
        mlen = rnd ? int'($urandom_range(1, 2 * P - 1)) : P;
      hold(1'b1, mlen);
      if (i != code.len() - 1) hold(1'b0, rnd ? int'($urandom_range(1, 2 * P - 1)) : P);
    end
    hold(1'b0, gap);
  endtask

  task automatic send_text(string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] != 8'h20) begin
        if (i == s.len() - 1 || s[i+1] == 8'h20) send_letter(code_of(s[i]), 7 * P, 0);
        else send_letter(code_of(s[i]), 3 * P, 0);
      end
    end
  endtask

  task automatic wait_drain(string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      tick();
      t++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every accepted character must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && vif.ascii_valid && vif.ascii_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_char", {24'h0, vif.ascii_out}, 32'hFFFF_FFFF);
      end else begin
        check("char", {24'h0, vif.ascii_out}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    string code;
    int gap;
    rst = 1'b1;
    morse_in = 1'b0;
    vif.ascii_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_valid", vif.ascii_valid, 0);
    check("reset_out", vif.ascii_out, 0);
    check("reset_overflow", overflow, 0);

    // 'E' with exact latencies for the letter and the following space
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h20);
    hold(1'b1, P);
    morse_in = 1'b0;
    tick();
    cnt = 0;
    while (!vif.ascii_valid && cnt < 1000) begin
      tick();
      cnt++;
    end
    check("e_latency", cnt, 201);
    check("e_char", vif.ascii_out, 8'h45);
    while (!(vif.ascii_valid && vif.ascii_out == 8'h20) && cnt < 1000) begin
      tick();
      cnt++;
    end
    check("space_latency", cnt, 501);
    hold(1'b0, 200);

    // Standard-timing phrase
    send_text("CARS ARE RED");
    wait_drain("phrase_drain");
    check("phrase_overflow", overflow, 0);

    // Digits and an over-long pattern
    send_letter("-----", 3 * P, 0);
    send_letter(".....", 3 * P, 0);
    send_letter("......", 7 * P, 0);
    wait_drain("digits_drain");

    // Mark and gap classification boundaries
    exp_q.push_back(8'h45);
    hold(1'b1, 199); hold(1'b0, 300);
    exp_q.push_back(8'h54);
    hold(1'b1, 200); hold(1'b0, 300);
    exp_q.push_back(8'h53);
    hold(1'b1, P); hold(1'b0, 199); hold(1'b1, P); hold(1'b0, 199); hold(1'b1, P); hold(1'b0, 300);
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h49);
    exp_q.push_back(8'h20);
    hold(1'b1, P); hold(1'b0, 200); hold(1'b1, P); hold(1'b0, P); hold(1'b1, P); hold(1'b0, 600);
    wait_drain("boundary_drain");

    // Backpressure: second letter and the space are dropped
    vif.ascii_ready = 1'b0;
    exp_q.push_back(8'h54);
    hold(1'b1, 3 * P); hold(1'b0, 3 * P); hold(1'b1, 3 * P); hold(1'b0, 7 * P);
    check("bp_valid", vif.ascii_valid, 1);
    check("bp_out", vif.ascii_out, 8'h54);
    check("bp_overflow", overflow, 1);
    vif.ascii_ready = 1'b1;
    tick();
    check("bp_valid_after_accept", vif.ascii_valid, 0);
    check("bp_queue", exp_q.size(), 0);
    repeat (20) tick();
    check("bp_overflow_sticky", overflow, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("bp_overflow_cleared", overflow, 0);

    // Reset during the second mark of a dot-dash
    hold(1'b1, P); hold(1'b0, P); hold(1'b1, 150);
    rst = 1'b1;
    morse_in = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_valid", vif.ascii_valid, 0);
    check("midrst_out", vif.ascii_out, 0);
    check("midrst_overflow", overflow, 0);
    hold(1'b0, 700);
    check("midrst_no_output", vif.ascii_valid, 0);
    send_letter(".-", 7 * P, 0);
    wait_drain("midrst_a_drain");

    // Randomized patterns, timings and consumer readiness
    rand_ready = 1;
    fork
      begin
        while (rand_ready) begin
          vif.ascii_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
      begin
        for (int k = 0; k < 16; k++) begin
          code = "";
          for (int j = 0; j < int'($urandom_range(1, 6)); j++)
            code = {code, ($urandom_range(0, 1) == 1) ? "-" : "."};
          gap = (k == 15 || $urandom_range(0, 3) == 0) ? int'($urandom_range(5 * P, 700))
                                                       : int'($urandom_range(2 * P, 5 * P - 1));
          send_letter(code, gap, 1);
        end
        rand_ready = 0;
      end
    join
    vif.ascii_ready = 1'b1;
    wait_drain("random_drain");
    check("random_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
